// File: rtl/ysyx_ifq_pkg.sv
// ysyx_ifq_pkg: shared defaults, entry layout and helpers for the instruction queue
package ysyx_ifq_pkg;

    localparam int DEF_XLEN    = 32;
    localparam int DEF_FETCH_W = 2;
    localparam int DEF_ISSUE_W = 2;
    localparam int DEF_DEPTH   = 8;
    localparam int PTR_W       = $clog2(DEF_DEPTH);
    localparam int CNT_W       = $clog2(DEF_DEPTH + 1);

    typedef struct packed {
        logic [31:0]         inst;
        logic [DEF_XLEN-1:0] pc;
        logic [DEF_XLEN-1:0] pnpc;
    } ifq_entry_t;

    function automatic int min_int(input int a, input int b);
        return a < b ? a : b;
    endfunction

endpackage

// File: rtl/ysyx_ifq_lead1.sv
// ysyx_ifq_lead1: counts consecutive ones starting at bit 0
module ysyx_ifq_lead1 #(
    parameter int W = 2
) (
    input  logic [W-1:0]               v,
    output logic [$clog2(W+1)-1:0]     n
);

    localparam int NW = $clog2(W + 1);

    logic run;

    always_comb begin
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < W; i++) begin
            run = run & v[i];
            n   = run ? NW'(i + 1) : n;
        end
    end

endmodule

// File: rtl/ysyx_ifq.sv
// ysyx_ifq: multi-lane circular instruction queue between fetch and decode.
// Define YSYX_IFQ_BYPASS_EN for a zero-latency in->out path when the queue is empty.
module ysyx_ifq
    import ysyx_ifq_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int FETCH_W = DEF_FETCH_W,
    parameter int ISSUE_W = DEF_ISSUE_W,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [FETCH_W-1:0]           in_valid,
    input  logic [FETCH_W*32-1:0]        in_inst,
    input  logic [FETCH_W*XLEN-1:0]      in_pc,
    input  logic [FETCH_W*XLEN-1:0]      in_pnpc,
    output logic                         in_ready,
    output logic [ISSUE_W-1:0]           out_valid,
    output logic [ISSUE_W*32-1:0]        out_inst,
    output logic [ISSUE_W*XLEN-1:0]      out_pc,
    output logic [ISSUE_W*XLEN-1:0]      out_pnpc,
    input  logic [$clog2(ISSUE_W+1)-1:0] out_deq,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = $clog2(FETCH_W + 1);

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pnpc;
    } entry_t;

    logic [AW-1:0] head, tail;
    logic [CW-1:0] cnt;
    entry_t        mem [DEPTH];
    logic [FW-1:0] npush_raw;
    logic          byp;
    int            npush, navail, npop, skip;

    ysyx_ifq_lead1 #(.W(FETCH_W)) u_lead (.v(in_valid), .n(npush_raw));

    assign in_ready = (DEPTH - int'(cnt)) >= FETCH_W;
    assign count    = cnt;

`ifdef YSYX_IFQ_BYPASS_EN
    assign byp = (cnt == '0) && !flush;
`else
    assign byp = 1'b0;
`endif

    // skip = lanes consumed straight from the input; they never touch storage or head
    always_comb begin
        npush  = in_ready ? int'(npush_raw) : 0;
        navail = byp ? min_int(npush, ISSUE_W) : min_int(int'(cnt), ISSUE_W);
        npop   = min_int(int'(out_deq), navail);
        skip   = byp ? npop : 0;
    end

    for (genvar i = 0; i < ISSUE_W; i++) begin : g_out
        entry_t e, q;
        assign q = mem[AW'(head + AW'(i))];
        if (i < FETCH_W) begin : g_byp
            assign e = byp ? {in_inst[i*32 +: 32], in_pc[i*XLEN +: XLEN], in_pnpc[i*XLEN +: XLEN]} : q;
        end else begin : g_q
            assign e = q;
        end
        assign out_valid[i]                = i < navail;
        assign out_inst[i*32 +: 32]        = e.inst;
        assign out_pc[i*XLEN +: XLEN]      = e.pc;
        assign out_pnpc[i*XLEN +: XLEN]    = e.pnpc;
    end

    always_ff @(posedge clock) begin
        if (!reset && !flush)
            for (int i = 0; i < FETCH_W; i++)
                if (i >= skip && i < npush)
                    mem[AW'(int'(tail) + i - skip)] <= {in_inst[i*32 +: 32], in_pc[i*XLEN +: XLEN], in_pnpc[i*XLEN +: XLEN]};
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= AW'(int'(head) + npop - skip);
            tail <= AW'(int'(tail) + npush - skip);
            cnt  <= CW'(int'(cnt) + npush - npop);
        end
    end

endmodule

// File: tb/tb_ysyx_ifq.sv
// tb_ysyx_ifq: scenario and randomized checks of ysyx_ifq against a queue-based model.
module tb_ysyx_ifq;

    localparam int FW    = 2;
    localparam int IW    = 2;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic [1:0]  in_valid;
    logic [63:0] in_inst, in_pc, in_pnpc;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_inst, out_pc, out_pnpc;
    logic [1:0]  out_deq;
    logic [3:0]  count;

    always #5 clk = ~clk;

    ysyx_ifq dut (
        .clock(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_pnpc(in_pnpc),
        .in_ready(in_ready), .out_valid(out_valid), .out_inst(out_inst),
        .out_pc(out_pc), .out_pnpc(out_pnpc), .out_deq(out_deq), .count(count)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pnpc;
    } ent_t;

    ent_t        q[$];
    int          checks = 0;
    int          failures = 0;
    bit          e_ready;
    int          e_npush, e_navail, e_npop;
    logic [1:0]  e_valid;
    ent_t        e_out[IW];
    logic [31:0] pc_seq = 32'h8000_0000;

    function automatic ent_t lane(input int i);
        ent_t e;
        e.inst = in_inst[i*32 +: 32];
        e.pc   = in_pc[i*32 +: 32];
        e.pnpc = in_pnpc[i*32 +: 32];
        return e;
    endfunction

    task automatic drive(input bit r, input bit f, input logic [1:0] v, input int d);
        reset    = r;
        flush    = f;
        in_valid = v;
        out_deq  = 2'(d);
        for (int i = 0; i < FW; i++) begin
            in_pc[i*32 +: 32]   = pc_seq + 32'(4 * i);
            in_inst[i*32 +: 32] = $urandom;
            in_pnpc[i*32 +: 32] = $urandom;
        end
        pc_seq = pc_seq + 32'(4 * FW);
    endtask

    // Expected outputs for the current cycle, from queue contents and the spec's rules
    task automatic settle();
        int  c;
        bit  byp;
        @(negedge clk);
        c       = q.size();
        e_ready = (DEPTH - c) >= FW;
        e_npush = 0;
        for (int i = 0; i < FW; i++)
            if (in_valid[i] && e_npush == i) e_npush++;
        if (!e_ready) e_npush = 0;
`ifdef YSYX_IFQ_BYPASS_EN
        byp = (c == 0) && !flush;
`else
        byp = 1'b0;
`endif
        e_navail = byp ? (e_npush < IW ? e_npush : IW) : (c < IW ? c : IW);
        e_npop   = int'(out_deq) < e_navail ? int'(out_deq) : e_navail;
        for (int i = 0; i < IW; i++) begin
            e_valid[i] = i < e_navail;
            e_out[i]   = byp ? lane(i) : (i < c ? q[i] : '{default: '0});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset || flush) q.delete();
        else begin
            for (int i = 0; i < e_npush; i++) q.push_back(lane(i));
            repeat (e_npop) void'(q.pop_front());
        end
        #1;
    endtask

    task automatic step(input bit r, input bit f, input logic [1:0] v, input int d);
        drive(r, f, v, d);
        settle();
        tick();
    endtask

    task automatic test_reset();
        step(1, 0, 2'b00, 0);
        drive(0, 0, 2'b00, 0);
        settle();
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b exp=00", out_valid); end
        tick();
    endtask

    task automatic test_basic();
        step(1, 0, 2'b00, 0);
        pc_seq = 32'h8000_0000;
        step(0, 0, 2'b11, 0);
        drive(0, 0, 2'b00, 0);
        settle();
        checks++; if (out_valid !== 2'b11) begin failures++; $display("FAIL basic_valid got=%b exp=11", out_valid); end
        checks++; if (out_pc[31:0] !== 32'h8000_0000) begin failures++; $display("FAIL basic_pc0 got=%h exp=80000000", out_pc[31:0]); end
        checks++; if (out_pc[63:32] !== 32'h8000_0004) begin failures++; $display("FAIL basic_pc1 got=%h exp=80000004", out_pc[63:32]); end
        checks++; if (out_inst[63:32] !== e_out[1].inst) begin failures++; $display("FAIL basic_inst1 got=%h exp=%h", out_inst[63:32], e_out[1].inst); end
        checks++; if (count !== 4'd2) begin failures++; $display("FAIL basic_count got=%0d exp=2", count); end
        tick();
    endtask

    task automatic test_full();
        step(1, 0, 2'b00, 0);
        pc_seq = 32'h8000_0000;
        repeat (4) step(0, 0, 2'b11, 0);
        pc_seq = 32'h8000_0100;
        drive(0, 0, 2'b11, 0);
        settle();
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", count); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", in_ready); end
        tick();
        drive(0, 0, 2'b00, 0);
        settle();
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL full_ignored got=%0d exp=8", count); end
        checks++; if (out_pc[31:0] !== 32'h8000_0000) begin failures++; $display("FAIL full_head got=%h exp=80000000", out_pc[31:0]); end
        tick();
    endtask

    task automatic test_wrap();
        logic [31:0] a, b, c;
        step(1, 0, 2'b00, 0);
        step(0, 0, 2'b11, 0);
        repeat (3) step(0, 0, 2'b11, 2);
        step(0, 0, 2'b01, 1);
        step(0, 0, 2'b01, 0);
        a = q[0].pc; b = q[1].pc; c = q[2].pc;
        drive(0, 0, 2'b11, 1);
        settle();
        checks++; if (count !== 4'd3) begin failures++; $display("FAIL wrap_setup got=%0d exp=3", count); end
        checks++; if (out_pc[31:0] !== a) begin failures++; $display("FAIL wrap_a got=%h exp=%h", out_pc[31:0], a); end
        tick();
        drive(0, 0, 2'b00, 0);
        settle();
        checks++; if (out_pc !== {c, b}) begin failures++; $display("FAIL wrap_bc got=%h exp=%h", out_pc, {c, b}); end
        checks++; if (count !== 4'd4) begin failures++; $display("FAIL wrap_count got=%0d exp=4", count); end
        tick();
    endtask

    task automatic test_noncontig();
        step(1, 0, 2'b00, 0);
        step(0, 0, 2'b10, 0);
        drive(0, 0, 2'b01, 0);
        settle();
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL noncontig_count got=%0d exp=0", count); end
        tick();
        drive(0, 0, 2'b00, 2);
        settle();
        checks++; if (out_valid !== 2'b01) begin failures++; $display("FAIL clamp_valid got=%b exp=01", out_valid); end
        tick();
        drive(0, 0, 2'b00, 0);
        settle();
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL clamp_count got=%0d exp=0", count); end
        tick();
    endtask

    task automatic test_flush();
        step(1, 0, 2'b00, 0);
        step(0, 0, 2'b11, 0);
        step(0, 0, 2'b11, 0);
        step(0, 0, 2'b01, 0);
        drive(0, 1, 2'b11, 2);
        settle();
        checks++; if (count !== 4'd5) begin failures++; $display("FAIL flush_setup got=%0d exp=5", count); end
        tick();
        drive(0, 0, 2'b00, 0);
        settle();
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 2'b00) begin failures++; $display("FAIL flush_valid got=%b exp=00", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
        tick();
    endtask

`ifdef YSYX_IFQ_BYPASS_EN
    task automatic test_bypass();
        logic [31:0] p0, p1;
        step(1, 0, 2'b00, 0);
        drive(0, 0, 2'b11, 1);
        p0 = in_pc[31:0];
        p1 = in_pc[63:32];
        settle();
        checks++; if (out_valid !== 2'b11) begin failures++; $display("FAIL bypass_valid got=%b exp=11", out_valid); end
        checks++; if (out_pc[31:0] !== p0) begin failures++; $display("FAIL bypass_pc0 got=%h exp=%h", out_pc[31:0], p0); end
        tick();
        drive(0, 0, 2'b00, 0);
        settle();
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL bypass_count got=%0d exp=1", count); end
        checks++; if (out_pc[31:0] !== p1) begin failures++; $display("FAIL bypass_rest got=%h exp=%h", out_pc[31:0], p1); end
        tick();
    endtask
`endif

    task automatic test_random();
        step(1, 0, 2'b00, 0);
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
                  2'($urandom), int'($urandom_range(0, 3)));
            settle();
            checks++; if (count !== 4'(q.size())) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", n, count, q.size()); end
            checks++; if (in_ready !== e_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", n, in_ready, e_ready); end
            checks++; if (out_valid !== e_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", n, out_valid, e_valid); end
            for (int i = 0; i < e_navail; i++) begin
                checks++;
                if (out_pc[i*32 +: 32] !== e_out[i].pc || out_inst[i*32 +: 32] !== e_out[i].inst ||
                    out_pnpc[i*32 +: 32] !== e_out[i].pnpc) begin
                    failures++;
                    $display("FAIL rnd_lane%0d cyc=%0d got=%h/%h/%h exp=%h/%h/%h", i, n,
                             out_pc[i*32 +: 32], out_inst[i*32 +: 32], out_pnpc[i*32 +: 32],
                             e_out[i].pc, e_out[i].inst, e_out[i].pnpc);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_noncontig();
        test_flush();
`ifdef YSYX_IFQ_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
